ram_dp_bytewise: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port, one read port, per-byte write enables.
- Configurable read latency (1 or 2) and read-during-write mode.
- Built-in memory-clear sequencer sweeps every location to zero after reset or on request, with a busy flag.
- General register-file / scratch-buffer successor to the fixed 8x8 RAM; used by datapath blocks needing wider or deeper storage.

---
 rtl/ram_dp_bytewise.sv | 125 ++++++++++++
 tb/tb_ram_dp_bytewise.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_bytewise.sv
// Simple-dual-port synchronous RAM with per-byte write enables, a 1- or
// 2-cycle registered read path, selectable read-during-write behaviour and
// a built-in sequencer that zeroes every word after reset or on request.
module ram_dp_bytewise #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_be,
  output logic                 wr_drop,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                clr_we;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_word;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;

  // Port arbitration: the sweep and a clear request both pre-empt user traffic.
  always_comb begin
    clr_we = (state == ST_CLEAR) && !reset;
    wr_acc = (state == ST_RUN) && !clear_req && !reset && wr_en;
    rd_acc = (state == ST_RUN) && !clear_req && !reset && rd_en;
  end

  // Read word, optionally forwarding same-address write bytes (new-data mode).
  always_comb begin
    // NOTE: the default assignment up front covers every path, so no latch is inferred.
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_acc && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Clear sequencer: CLEAR sweeps one word per cycle, RUN serves traffic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && ((state == ST_CLEAR) || clear_req);
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage array: sweep writes zero, user writes merge enabled bytes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the clear sequencer defines its contents instead.
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline: one or two register stages; rd_data holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
      if (RD_LAT == 1) begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word;
      end else begin
        // In-flight stage-1 reads finish even if a clear has just started.
        rd_valid <= s1_valid;
        if (s1_valid) rd_data <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_bytewise.sv
// Self-checking bench: two RAM instances (latency 1 / old-data and
// latency 2 / new-data) share one stimulus stream and are compared every
// cycle against a behavioural model, plus directed value checks.
module tb_ram_dp_bytewise;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [2:0]  rd_addr;

  logic        busy0, busy1, drop0, drop1, valid0, valid1;
  logic [15:0] data0, data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_dp_bytewise #(.DATA_W(16), .ADDR_W(3), .RD_LAT(1), .RDW_MODE(0)) u_l1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_drop(drop0), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data0), .rd_valid(valid0)
  );

  ram_dp_bytewise #(.DATA_W(16), .ADDR_W(3), .RD_LAT(2), .RDW_MODE(1)) u_l2 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_drop(drop1), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(data1), .rd_valid(valid1)
  );

  // ---------------- reference model ----------------
  logic [15:0] mem_m [8];
  logic        m_busy = 1'b1;
  int          m_clr  = 0;
  logic        e_drop = 1'b0;
  logic        e_valid0 = 1'b0, e_valid1 = 1'b0;
  logic [15:0] e_data0 = '0, e_data1 = '0;
  logic [16:0] q1 [$];

  function automatic logic [15:0] merge(input logic [15:0] old_w,
                                        input logic [15:0] new_w,
                                        input logic [1:0]  be);
    logic [15:0] res;
    res = old_w;
    for (int b = 0; b < 2; b++) if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  task automatic model_edge();
    logic        acc;
    logic [15:0] rw0, rw1;
    logic [16:0] ent;
    if (reset) begin
      m_busy = 1'b1; m_clr = 0; e_drop = 1'b0;
      e_valid0 = 1'b0; e_data0 = '0; e_valid1 = 1'b0; e_data1 = '0;
      q1.delete(); q1.push_back(17'h0);
    end else begin
      acc = 1'b0; rw0 = '0; rw1 = '0; e_drop = 1'b0;
      if (m_busy) begin
        mem_m[m_clr] = '0;
        m_clr++;
        if (m_clr == 8) m_busy = 1'b0;
        e_drop = wr_en;
      end else if (clear_req) begin
        m_busy = 1'b1; m_clr = 0; e_drop = wr_en;
      end else begin
        if (rd_en) begin
          acc = 1'b1;
          rw0 = mem_m[rd_addr];
          rw1 = (wr_en && wr_addr == rd_addr) ? merge(mem_m[rd_addr], wr_data, wr_be)
                                               : mem_m[rd_addr];
        end
        if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
      end
      e_valid0 = acc;
      if (acc) e_data0 = rw0;
      q1.push_back({acc, rw1});
      ent = q1.pop_front();
      e_valid1 = ent[16];
      if (ent[16]) e_data1 = ent[15:0];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("busy_l1",   32'(busy0),  32'(m_busy));
    check("busy_l2",   32'(busy1),  32'(m_busy));
    check("drop_l1",   32'(drop0),  32'(e_drop));
    check("drop_l2",   32'(drop1),  32'(e_drop));
    check("valid_l1",  32'(valid0), 32'(e_valid0));
    check("valid_l2",  32'(valid1), 32'(e_valid1));
    check("data_l1",   32'(data0),  32'(e_data0));
    check("data_l2",   32'(data1),  32'(e_data1));
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; reset = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    do_cycle();
    wr_en = 1'b0;
  endtask

  // Counts busy cycles after a reset or clear edge, bounded to 20 cycles.
  task automatic count_busy(output int cnt);
    cnt = busy0 ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy0) break;
      do_cycle();
      if (busy0) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    q1.push_back(17'h0);
    reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;

    // Reset for 3 cycles, then the sweep must take exactly 8 cycles.
    repeat (3) do_cycle();
    check("reset_valid", 32'(valid0), 32'd0);
    check("reset_data",  32'(data0),  32'd0);
    idle();
    count_busy(cnt);
    check("sweep_len", 32'(cnt), 32'd8);

    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      do_cycle();
      check("post_sweep_zero", 32'(data0), 32'h0);
      check("post_sweep_valid", 32'(valid0), 32'd1);
    end
    idle(); do_cycle();

    // Byte-enable merge.
    write(3'd5, 16'hA55A, 2'b11);
    write(3'd5, 16'h1234, 2'b01);
    rd_en = 1'b1; rd_addr = 3'd5;
    do_cycle();
    rd_en = 1'b0;
    check("merge_l1", 32'(data0), 32'hA534);
    check("merge_l1_valid", 32'(valid0), 32'd1);
    do_cycle();
    check("merge_l2", 32'(data1), 32'hA534);

    // Read during write to the same address.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 3'd2;
    do_cycle();
    idle();
    check("rdw_old", 32'(data0), 32'h0000);
    do_cycle();
    check("rdw_new", 32'(data1), 32'hBEEF);
    rd_en = 1'b1; rd_addr = 3'd2;
    do_cycle();
    rd_en = 1'b0;
    check("rdw_after_l1", 32'(data0), 32'hBEEF);
    do_cycle();
    check("rdw_after_l2", 32'(data1), 32'hBEEF);

    // Back-to-back reads through the 2-stage pipe.
    write(3'd0, 16'h0011, 2'b11);
    write(3'd1, 16'h0022, 2'b11);
    write(3'd2, 16'h0033, 2'b11);
    for (int a = 0; a < 3; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      do_cycle();
    end
    rd_en = 1'b0;
    check("stream_mid", 32'(data1), 32'h0022);
    do_cycle();
    check("stream_last", 32'(data1), 32'h0033);
    check("stream_last_valid", 32'(valid1), 32'd1);
    do_cycle();
    check("stream_hold", 32'(data1), 32'h0033);
    check("stream_hold_valid", 32'(valid1), 32'd0);

    // Clear request with a concurrent write, plus a mid-sweep write.
    for (int a = 0; a < 8; a++) write(3'(a), 16'($urandom) | 16'h0101, 2'b11);
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hFFFF; wr_be = 2'b11;
    do_cycle();
    idle();
    check("clear_drop", 32'(drop0), 32'd1);
    check("clear_busy", 32'(busy0), 32'd1);
    do_cycle(); do_cycle();
    write(3'd6, 16'h7777, 2'b11);
    check("sweep_drop", 32'(drop0), 32'd1);
    for (int i = 0; i < 20 && busy0; i++) do_cycle();
    check("clear_done", 32'(busy0), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 3'(a);
      do_cycle();
      check("clear_zero", 32'(data0), 32'h0);
    end
    idle();

    // Reset in the middle of a latency-2 read stream.
    write(3'd1, 16'h5A5A, 2'b11);
    rd_en = 1'b1; rd_addr = 3'd1;
    do_cycle();
    reset = 1'b1;
    do_cycle();
    check("rst_stream_valid", 32'(valid1), 32'd0);
    check("rst_stream_data",  32'(data1),  32'd0);
    idle();
    count_busy(cnt);
    check("rst_sweep_len", 32'(cnt), 32'd8);

    // Reset in the middle of a clear sweep restarts it.
    clear_req = 1'b1;
    do_cycle();
    idle();
    repeat (3) do_cycle();
    reset = 1'b1;
    do_cycle();
    idle();
    count_busy(cnt);
    check("restart_sweep_len", 32'(cnt), 32'd8);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clear_req = ($urandom_range(0, 39) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      rd_en     = $urandom_range(0, 1) == 1;
      wr_addr   = 3'($urandom_range(0, 7));
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      wr_data   = 16'($urandom);
      wr_be     = 2'($urandom_range(0, 3));
      do_cycle();
    end
    idle();
    repeat (4) do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
